// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, special register IDs and data width.
// Every pipeline/SEQ stage imports this so encodings stay consistent.
package y86_pkg;

    localparam int WIDTH_DEFAULT = 64;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RRSP  = 4'd4;
    localparam logic [3:0] RNONE = 4'hF;

endpackage

// File: rtl/wb_dst_decode.sv
// Register selection for a SEQ instruction: source read ports and E/M write destinations.
// Shared with the decode stage so both ends of the register file pick the same registers.
module wb_dst_decode
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    input  logic       cnd,
    input  logic [3:0] rA,
    input  logic [3:0] rB,
    output logic [3:0] srcA,
    output logic [3:0] srcB,
    output logic [3:0] dstE,
    output logic [3:0] dstM
);

    always_comb begin
        srcA = RNONE;
        srcB = RNONE;
        dstE = RNONE;
        dstM = RNONE;

        case (icode)
            IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ: srcA = rA;
            IRET, IPOPQ:                    srcA = RRSP;
            default:                        srcA = RNONE;
        endcase

        case (icode)
            IRMMOVQ, IMRMOVQ, IOPQ:      srcB = rB;
            ICALL, IRET, IPUSHQ, IPOPQ:  srcB = RRSP;
            default:                     srcB = RNONE;
        endcase

        // A cmov that fails its condition turns into a write to nowhere
        case (icode)
            IRRMOVQ:                     dstE = cnd ? rB : RNONE;
            IIRMOVQ, IOPQ:               dstE = rB;
            ICALL, IRET, IPUSHQ, IPOPQ:  dstE = RRSP;
            default:                     dstE = RNONE;
        endcase

        case (icode)
            IMRMOVQ, IPOPQ: dstM = rA;
            default:        dstM = RNONE;
        endcase
    end

endmodule

// File: rtl/writeback_regfile.sv
// SEQ write-back register file: 15 Y86-64 registers with combinational read ports,
// clocked E/M commit and a sticky halt flag that freezes state until reset.
module writeback_regfile
    import y86_pkg::*;
#(
    parameter int               WIDTH    = WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] RSP_INIT = '0,
    parameter int               NREGS    = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wb_en,
    input  logic [3:0]       icode,
    input  logic             cnd,
    input  logic [3:0]       rA,
    input  logic [3:0]       rB,
    input  logic [WIDTH-1:0] valE,
    input  logic [WIDTH-1:0] valM,
    output logic [WIDTH-1:0] valA,
    output logic [WIDTH-1:0] valB,
    output logic [3:0]       dstE,
    output logic [3:0]       dstM,
    output logic             halted,
    input  logic [3:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    logic [WIDTH-1:0] regs [NREGS];
    logic [3:0]       srcA;
    logic [3:0]       srcB;
    logic             commit;

    wb_dst_decode u_dst_decode (
        .icode (icode),
        .cnd   (cnd),
        .rA    (rA),
        .rB    (rB),
        .srcA  (srcA),
        .srcB  (srcB),
        .dstE  (dstE),
        .dstM  (dstM)
    );

    // Reads see pre-edge contents; there is deliberately no write-to-read bypass
    assign valA     = (srcA == RNONE)     ? '0 : regs[srcA];
    assign valB     = (srcB == RNONE)     ? '0 : regs[srcB];
    assign dbg_data = (dbg_addr == RNONE) ? '0 : regs[dbg_addr];

    assign commit = wb_en && !halted;

    // The M write is issued after the E write so it wins when both target the same register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= (i == int'(RRSP)) ? RSP_INIT : '0;
            end
            halted <= 1'b0;
        end else if (commit) begin
            if (icode == IHALT) begin
                halted <= 1'b1;
            end
            if (dstE != RNONE) begin
                regs[dstE] <= valE;
            end
            if (dstM != RNONE) begin
                regs[dstM] <= valM;
            end
        end
    end

endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile: reset state, directed corner sequences,
// a decode vector table and randomized traffic against an instruction-level model.
module tb_writeback_regfile;
    import y86_pkg::*;

    localparam int          W   = 64;
    localparam logic [63:0] RSP = 64'h100;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wb_en;
    logic [3:0]    icode;
    logic          cnd;
    logic [3:0]    rA;
    logic [3:0]    rB;
    logic [W-1:0]  valE;
    logic [W-1:0]  valM;
    logic [W-1:0]  valA;
    logic [W-1:0]  valB;
    logic [3:0]    dstE;
    logic [3:0]    dstM;
    logic          halted;
    logic [3:0]    dbg_addr;
    logic [W-1:0]  dbg_data;

    int checks = 0;
    int passes = 0;

    logic [63:0] mreg [16];
    logic        mhalt;

    typedef struct {
        logic [3:0] icode;
        logic [3:0] rA;
        logic [3:0] rB;
        logic       cnd;
        logic [3:0] expDstE;
        logic [3:0] expDstM;
    } dec_vec_t;

    dec_vec_t vecs [15];

    writeback_regfile #(.WIDTH(W), .RSP_INIT(RSP)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_en    (wb_en),
        .icode    (icode),
        .cnd      (cnd),
        .rA       (rA),
        .rB       (rB),
        .valE     (valE),
        .valM     (valM),
        .valA     (valA),
        .valB     (valB),
        .dstE     (dstE),
        .dstM     (dstM),
        .halted   (halted),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1, "[TB] timeout");
    end

    // Instruction-level reference: which operands each instruction reads and writes
    function automatic logic [3:0] refSrcA(input logic [3:0] ic, input logic [3:0] ra);
        case (ic)
            IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ: return ra;
            IRET, IPOPQ:                    return RRSP;
            default:                        return RNONE;
        endcase
    endfunction

    function automatic logic [3:0] refSrcB(input logic [3:0] ic, input logic [3:0] rb);
        case (ic)
            IRMMOVQ, IMRMOVQ, IOPQ:     return rb;
            ICALL, IRET, IPUSHQ, IPOPQ: return RRSP;
            default:                    return RNONE;
        endcase
    endfunction

    function automatic logic [63:0] modelRead(input logic [3:0] a);
        return (a == 4'hF) ? 64'h0 : mreg[a];
    endfunction

    task automatic modelPut(input logic [3:0] idx, input logic [63:0] v);
        if (idx != 4'hF) mreg[idx] = v;
    endtask

    task automatic modelReset();
        for (int i = 0; i < 16; i++) mreg[i] = 64'h0;
        mreg[4] = RSP;
        mhalt   = 1'b0;
    endtask

    task automatic modelCommit(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                               input logic c, input logic [63:0] ve, input logic [63:0] vm);
        if (!mhalt) begin
            case (ic)
                IHALT:                      mhalt = 1'b1;
                IRRMOVQ:                    if (c) modelPut(rb, ve);
                IIRMOVQ, IOPQ:              modelPut(rb, ve);
                IMRMOVQ:                    modelPut(ra, vm);
                ICALL, IRET, IPUSHQ:        modelPut(RRSP, ve);
                IPOPQ: begin
                    modelPut(RRSP, ve);
                    modelPut(ra, vm);
                end
                default: ;
            endcase
        end
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic applyStimulus(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                                 input logic c, input logic [63:0] ve, input logic [63:0] vm,
                                 input logic wb);
        icode = ic;
        rA    = ra;
        rB    = rb;
        cnd   = c;
        valE  = ve;
        valM  = vm;
        wb_en = wb;
    endtask

    // One instruction: drive at negedge, check pre-edge reads, commit in the model at the edge
    task automatic stepInstr(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                             input logic c, input logic [63:0] ve, input logic [63:0] vm,
                             input logic wb);
        @(negedge clk);
        applyStimulus(ic, ra, rb, c, ve, vm, wb);
        #1;
        checkOutput("valA_pre", valA, modelRead(refSrcA(ic, ra)));
        checkOutput("valB_pre", valB, modelRead(refSrcB(ic, rb)));
        @(posedge clk);
        if (wb) modelCommit(ic, ra, rb, c, ve, vm);
        #1;
    endtask

    task automatic checkReg(input string name, input logic [3:0] a);
        dbg_addr = a;
        #1;
        checkOutput(name, dbg_data, modelRead(a));
    endtask

    initial begin
        vecs[0]  = '{4'h0, 4'h1, 4'h2, 1'b0, 4'hF, 4'hF};
        vecs[1]  = '{4'h1, 4'h1, 4'h2, 1'b1, 4'hF, 4'hF};
        vecs[2]  = '{4'h2, 4'h1, 4'h8, 1'b0, 4'hF, 4'hF};
        vecs[3]  = '{4'h2, 4'h1, 4'h8, 1'b1, 4'h8, 4'hF};
        vecs[4]  = '{4'h3, 4'hF, 4'h2, 1'b0, 4'h2, 4'hF};
        vecs[5]  = '{4'h4, 4'h1, 4'h2, 1'b1, 4'hF, 4'hF};
        vecs[6]  = '{4'h5, 4'h3, 4'h6, 1'b0, 4'hF, 4'h3};
        vecs[7]  = '{4'h6, 4'h2, 4'h7, 1'b0, 4'h7, 4'hF};
        vecs[8]  = '{4'h7, 4'h2, 4'h7, 1'b1, 4'hF, 4'hF};
        vecs[9]  = '{4'h8, 4'hF, 4'hF, 1'b0, 4'h4, 4'hF};
        vecs[10] = '{4'h9, 4'hF, 4'hF, 1'b0, 4'h4, 4'hF};
        vecs[11] = '{4'hA, 4'h3, 4'hF, 1'b0, 4'h4, 4'hF};
        vecs[12] = '{4'hB, 4'h4, 4'hF, 1'b0, 4'h4, 4'h4};
        vecs[13] = '{4'hC, 4'h1, 4'h2, 1'b1, 4'hF, 4'hF};
        vecs[14] = '{4'hF, 4'h1, 4'h2, 1'b1, 4'hF, 4'hF};

        rst_n    = 1'b0;
        dbg_addr = 4'h0;
        applyStimulus(4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0);
        modelReset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state, including the RNONE address
        for (int i = 0; i < 16; i++) checkReg($sformatf("reset_reg%0d", i), 4'(i));
        checkOutput("reset_halted", 64'(halted), 64'h0);

        // irmovq then opq reading the same register; pre-edge read sees the old value
        @(negedge clk);
        applyStimulus(IIRMOVQ, 4'hF, 4'h2, 1'b0, 64'd55, 64'h0, 1'b1);
        dbg_addr = 4'h2;
        #1;
        checkOutput("irmov_preedge", dbg_data, 64'h0);
        @(posedge clk);
        modelCommit(IIRMOVQ, 4'hF, 4'h2, 1'b0, 64'd55, 64'h0);
        #1;
        checkOutput("irmov_reg2", dbg_data, 64'd55);
        @(negedge clk);
        applyStimulus(IOPQ, 4'h2, 4'h2, 1'b0, 64'h0, 64'h0, 1'b0);
        #1;
        checkOutput("opq_valA", valA, 64'd55);
        checkOutput("opq_valB", valB, 64'd55);

        // cmov with condition false, then true
        @(negedge clk);
        applyStimulus(IRRMOVQ, 4'h1, 4'h8, 1'b0, 64'd7, 64'h0, 1'b1);
        #1;
        checkOutput("cmov0_dstE", 64'(dstE), 64'hF);
        @(posedge clk);
        modelCommit(IRRMOVQ, 4'h1, 4'h8, 1'b0, 64'd7, 64'h0);
        #1;
        checkReg("cmov0_reg8", 4'h8);
        @(negedge clk);
        applyStimulus(IRRMOVQ, 4'h1, 4'h8, 1'b1, 64'd7, 64'h0, 1'b1);
        #1;
        checkOutput("cmov1_dstE", 64'(dstE), 64'h8);
        @(posedge clk);
        modelCommit(IRRMOVQ, 4'h1, 4'h8, 1'b1, 64'd7, 64'h0);
        #1;
        checkOutput("cmov1_reg8", modelRead(4'h8), 64'd7);
        checkReg("cmov1_reg8_dut", 4'h8);

        // popq %rsp: M write wins over E write on the same register
        stepInstr(IPOPQ, 4'h4, 4'hF, 1'b0, 64'h108, 64'hDEAD, 1'b1);
        dbg_addr = 4'h4;
        #1;
        checkOutput("popq_rsp", dbg_data, 64'hDEAD);
        @(negedge clk);
        applyStimulus(IPUSHQ, 4'h3, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0);
        #1;
        checkOutput("pushq_dstE", 64'(dstE), 64'h4);
        checkOutput("pushq_valB", valB, 64'hDEAD);

        // Decode table with wb_en low: outputs follow inputs, no state change
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].icode, vecs[i].rA, vecs[i].rB, vecs[i].cnd,
                          64'hFFFF_0000_FFFF_0000, 64'h1234, 1'b0);
            #1;
            checkOutput($sformatf("vec%0d_dstE", i), 64'(dstE), 64'(vecs[i].expDstE));
            checkOutput($sformatf("vec%0d_dstM", i), 64'(dstM), 64'(vecs[i].expDstM));
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) checkReg($sformatf("nowb_reg%0d", i), 4'(i));

        // Randomized traffic (no halt), checked against the instruction model
        for (int n = 0; n < 400; n++) begin
            logic [3:0]  ic;
            logic [63:0] ve;
            logic [63:0] vm;
            ic = 4'($urandom_range(1, 15));
            ve = {$urandom, $urandom};
            vm = {$urandom, $urandom};
            stepInstr(ic, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)), ve, vm, ($urandom_range(0, 3) != 0));
            checkReg($sformatf("rand%0d_dbg", n), 4'($urandom_range(0, 15)));
            checkOutput($sformatf("rand%0d_halted", n), 64'(halted), 64'h0);
        end

        // Halt, then a blocked irmovq
        stepInstr(IHALT, 4'h1, 4'h2, 1'b0, 64'h5, 64'h6, 1'b1);
        checkOutput("halt_set", 64'(halted), 64'h1);
        stepInstr(IIRMOVQ, 4'hF, 4'h1, 1'b0, 64'd9, 64'h0, 1'b1);
        checkOutput("halt_sticky", 64'(halted), 64'h1);
        checkReg("halt_reg1", 4'h1);
        checkReg("halt_reg2", 4'h2);

        // Asynchronous reset between edges while a commit is presented
        @(negedge clk);
        applyStimulus(IIRMOVQ, 4'hF, 4'h5, 1'b0, 64'd99, 64'h0, 1'b1);
        dbg_addr = 4'h5;
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("midrst_reg5", dbg_data, 64'h0);
        checkOutput("midrst_halted", 64'(halted), 64'h0);
        checkReg("midrst_reg4", 4'h4);
        @(posedge clk);
        #1;
        checkReg("rsthold_reg5", 4'h5);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        modelCommit(IIRMOVQ, 4'hF, 4'h5, 1'b0, 64'd99, 64'h0);
        #1;
        dbg_addr = 4'h5;
        #1;
        checkOutput("postrst_reg5", dbg_data, 64'd99);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
